// File: rtl/dpram_portb_arbiter.sv
// Purpose : round-robin arbiter for RAM port B, shared by r0 (effect engine) and r1 (sample streamer).
// Latency : grant and RAM drive are combinational; read data returns one cycle after the grant.
// Backpressure: a requester holds req until gnt; only one access per cycle, no requester waits more than 2 cycles.
//
// Ports:
//   csi_clk / rsi_reset     block clock (also RAM port B clock), asynchronous active-high reset
//   rX_req/we/addr/wdata    requester X access (X = 0, 1), held stable until rX_gnt
//   rX_gnt                  access accepted this cycle
//   rX_rvalid / rX_rdata    read return for requester X, one cycle after a read grant
//   ram_address/writedata/wren, ram_readdata   RAM port B (address registered inside the RAM)
//   ctrl_word / ctrl_valid  mirrored control word at CTRL_ADDR
//
// Optional feature macro: DPRAM_CTRL_MIRROR_EN
//   defined   : every REFRESH_CYCLES cycles a refresh read of CTRL_ADDR steals one grant slot and the
//               returned word is mirrored into ctrl_word (ctrl_valid sticky after the first refresh).
//   undefined : no refresh traffic; ctrl_word and ctrl_valid are tied to 0.
module dpram_portb_arbiter #(
    parameter int AW             = 5,
    parameter int DW             = 32,
    parameter int CTRL_ADDR      = 31,
    parameter int REFRESH_CYCLES = 256
) (
    input  logic          csi_clk,
    input  logic          rsi_reset,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_writedata,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_readdata,
    output logic [DW-1:0] ctrl_word,
    output logic          ctrl_valid
);

    // Elaboration-time parameter guard: the refresh interval must leave room for traffic and the
    // control word must be addressable.
    if (REFRESH_CYCLES < 2 || CTRL_ADDR < 0 || CTRL_ADDR >= (1 << AW)) begin : g_bad_params
        $error("dpram_portb_arbiter: unsupported REFRESH_CYCLES/CTRL_ADDR for this AW");
    end

    // last_q = id of the requester served most recently; resets to 1 so r0 wins the first tie.
    logic last_q, last_d;
    // Read-return tag: a read was granted last cycle, and to whom.
    logic tag_vld_q, tag_vld_d;
    logic tag_id_q, tag_id_d;

    logic ref_pend;
    logic gnt0, gnt1;

`ifdef DPRAM_CTRL_MIRROR_EN
    localparam int CW = $clog2(REFRESH_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tag_ref_q, tag_ref_d;
    logic [DW-1:0] ctrl_word_q, ctrl_word_d;
    logic          ctrl_valid_q, ctrl_valid_d;

    // Counter sits at 0 out of reset, so the first refresh issues in the first cycle after release.
    assign ref_pend = ~rsi_reset & (cnt_q == '0);

    always_comb begin
        cnt_d        = ref_pend ? CW'(REFRESH_CYCLES - 1) : cnt_q - CW'(1);
        tag_ref_d    = ref_pend;
        ctrl_word_d  = ctrl_word_q;
        ctrl_valid_d = ctrl_valid_q;
        // RAM output is valid the cycle after the refresh address was presented.
        if (tag_ref_q) begin
            ctrl_word_d  = ram_readdata;
            ctrl_valid_d = 1'b1;
        end
    end

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            cnt_q        <= '0;
            tag_ref_q    <= 1'b0;
            ctrl_word_q  <= '0;
            ctrl_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            tag_ref_q    <= tag_ref_d;
            ctrl_word_q  <= ctrl_word_d;
            ctrl_valid_q <= ctrl_valid_d;
        end
    end

    assign ctrl_word  = ctrl_word_q;
    assign ctrl_valid = ctrl_valid_q;
`else
    assign ref_pend   = 1'b0;
    assign ctrl_word  = '0;
    assign ctrl_valid = 1'b0;
`endif

    // Arbitration: refresh first, then a sole requester, then the one not served last.
    // Gated by reset so outputs fall to idle as soon as reset asserts.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rsi_reset && !ref_pend) begin
            if (r0_req && (!r1_req || last_q)) begin
                gnt0 = 1'b1;
            end else if (r1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign r0_gnt = gnt0;
    assign r1_gnt = gnt1;

    // RAM port B follows the winner; refresh is a read of CTRL_ADDR; idle drives zeros.
    always_comb begin
        ram_address   = '0;
        ram_writedata = '0;
        ram_wren      = 1'b0;
        if (gnt0) begin
            ram_address   = r0_addr;
            ram_writedata = r0_wdata;
            ram_wren      = r0_we;
        end else if (gnt1) begin
            ram_address   = r1_addr;
            ram_writedata = r1_wdata;
            ram_wren      = r1_we;
        end else if (ref_pend) begin
            ram_address   = AW'(CTRL_ADDR);
        end
    end

    always_comb begin
        last_d    = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
        tag_vld_d = (gnt0 & ~r0_we) | (gnt1 & ~r1_we);
        tag_id_d  = gnt1;
    end

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            last_q    <= 1'b1;
            tag_vld_q <= 1'b0;
            tag_id_q  <= 1'b0;
        end else begin
            last_q    <= last_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    // Read return: the RAM output is routed to the tagged requester only; the other sees 0.
    assign r0_rvalid = tag_vld_q & ~tag_id_q;
    assign r1_rvalid = tag_vld_q &  tag_id_q;
    assign r0_rdata  = r0_rvalid ? ram_readdata : '0;
    assign r1_rdata  = r1_rvalid ? ram_readdata : '0;

endmodule

// File: tb/tb_dpram_portb_arbiter.sv
// Purpose : self-checking bench for dpram_portb_arbiter with a behavioural RAM and reference model.
// Latency : model predicts grants in-cycle and read returns one cycle after each read grant.
// Backpressure: bench requesters hold requests until granted, as the arbiter expects.
module tb_dpram_portb_arbiter;

    localparam int AW        = 5;
    localparam int DW        = 32;
    localparam int CTRL_ADDR = 31;
    localparam int RC        = 256;
`ifdef DPRAM_CTRL_MIRROR_EN
    localparam bit MIRROR = 1'b1;
`else
    localparam bit MIRROR = 1'b0;
`endif

    logic          csi_clk   = 1'b0;
    logic          rsi_reset = 1'b1;
    logic          r0_req, r0_we, r1_req, r1_we;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_writedata, ram_readdata, ctrl_word;
    logic          ram_wren, ctrl_valid;

    // Host port A of the RAM, driven by the bench.
    logic          host_we   = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_dat  = '0;

    always #5 csi_clk = ~csi_clk;

    dpram_portb_arbiter #(.AW(AW), .DW(DW), .CTRL_ADDR(CTRL_ADDR), .REFRESH_CYCLES(RC)) dut (
        .csi_clk(csi_clk), .rsi_reset(rsi_reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .ram_address(ram_address), .ram_writedata(ram_writedata), .ram_wren(ram_wren),
        .ram_readdata(ram_readdata), .ctrl_word(ctrl_word), .ctrl_valid(ctrl_valid)
    );

    // Behavioural dual-port RAM: registered address, unregistered output.
    logic [DW-1:0] mem [0:31];
    logic [AW-1:0] areg = '0;
    always @(posedge csi_clk) begin
        if (host_we)  mem[host_addr]   <= host_dat;
        if (ram_wren) mem[ram_address] <= ram_writedata;
        areg <= ram_address;
    end
    assign ram_readdata = mem[areg];

    // Reference model state.
    logic [DW-1:0] mm [0:31];
    int            cyc;
    bit            last;
    bit            pend_vld;
    bit            pend_id;
    logic [AW-1:0] pend_addr;
    bit            ref_tag;
    logic [DW-1:0] exp_ctrl;
    bit            exp_ctrl_vld;
    int            waitc [2];

    // Requester stimulus state.
    bit            q_req [2];
    bit            q_we  [2];
    logic [AW-1:0] q_addr [2];
    logic [DW-1:0] q_wd  [2];
    bit            rand_mode = 1'b0;
    bit            h_we = 1'b0;
    logic [DW-1:0] h_dat = '0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc          = 0;
        last         = 1'b1;
        pend_vld     = 1'b0;
        pend_id      = 1'b0;
        pend_addr    = '0;
        ref_tag      = 1'b0;
        exp_ctrl     = '0;
        exp_ctrl_vld = 1'b0;
        waitc[0]     = 0;
        waitc[1]     = 0;
    endtask

    task automatic new_req(input int i);
        q_req[i]  = ($urandom_range(0, 9) < 6);
        q_we[i]   = ($urandom_range(0, 9) < 3);
        q_addr[i] = AW'($urandom_range(0, 30));
        q_wd[i]   = $urandom;
    endtask

    task automatic drive();
        r0_req = q_req[0]; r0_we = q_we[0]; r0_addr = q_addr[0]; r0_wdata = q_wd[0];
        r1_req = q_req[1]; r1_we = q_we[1]; r1_addr = q_addr[1]; r1_wdata = q_wd[1];
        host_we = h_we; host_addr = AW'(CTRL_ADDR); host_dat = h_dat;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_r0_gnt"}, r0_gnt, 0);
        check({tag, "_r1_gnt"}, r1_gnt, 0);
        check({tag, "_r0_rvalid"}, r0_rvalid, 0);
        check({tag, "_r1_rvalid"}, r1_rvalid, 0);
        check({tag, "_ram_address"}, ram_address, 0);
        check({tag, "_ram_wren"}, ram_wren, 0);
        check({tag, "_ram_writedata"}, ram_writedata, 0);
        check({tag, "_ctrl_word"}, ctrl_word, 0);
        check({tag, "_ctrl_valid"}, ctrl_valid, 0);
    endtask

    // One clock cycle: drive, compare against the model, then advance the model past the edge.
    task automatic cycle();
        int            w;
        bit            eref;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        bit            ewe;
        logic [DW-1:0] exp_rd;
        @(negedge csi_clk);
        drive();
        #1;
        // Refresh reads fall every RC cycles counted from reset release, starting at cycle 0.
        eref = MIRROR && ((cyc % RC) == 0);
        w = -1;
        if (!eref) begin
            if (q_req[0] && q_req[1]) w = last ? 0 : 1;
            else if (q_req[0])        w = 0;
            else if (q_req[1])        w = 1;
        end
        ea  = eref ? AW'(CTRL_ADDR) : '0;
        ed  = '0;
        ewe = 1'b0;
        if (w >= 0) begin
            ea = q_addr[w]; ed = q_wd[w]; ewe = q_we[w];
        end
        check("r0_gnt", r0_gnt, w == 0);
        check("r1_gnt", r1_gnt, w == 1);
        check("ram_address", ram_address, ea);
        check("ram_writedata", ram_writedata, ed);
        check("ram_wren", ram_wren, ewe);
        exp_rd = pend_vld ? mm[pend_addr] : '0;
        check("r0_rvalid", r0_rvalid, pend_vld && !pend_id);
        check("r0_rdata", r0_rdata, (pend_vld && !pend_id) ? exp_rd : '0);
        check("r1_rvalid", r1_rvalid, pend_vld && pend_id);
        check("r1_rdata", r1_rdata, (pend_vld && pend_id) ? exp_rd : '0);
        check("ctrl_word", ctrl_word, exp_ctrl);
        check("ctrl_valid", ctrl_valid, exp_ctrl_vld);
        for (int i = 0; i < 2; i++) begin
            if (q_req[i] && w == i) begin
                check("rr_wait_bound", waitc[i] <= (MIRROR ? 3 : 2), 1);
                waitc[i] = 0;
            end else if (q_req[i]) begin
                waitc[i]++;
            end else begin
                waitc[i] = 0;
            end
        end
        // Advance the model across the clock edge.
        if (ref_tag) begin
            exp_ctrl     = mm[CTRL_ADDR];
            exp_ctrl_vld = 1'b1;
        end
        ref_tag  = eref;
        pend_vld = (w >= 0) && !q_we[w];
        if (w >= 0) begin
            pend_id   = (w == 1);
            pend_addr = q_addr[w];
            last      = (w == 1);
            if (q_we[w]) mm[q_addr[w]] = q_wd[w];
        end
        if (h_we) mm[CTRL_ADDR] = h_dat;
        h_we = 1'b0;
        cyc++;
        if (w >= 0) q_req[w] = 1'b0;
        if (rand_mode) begin
            for (int i = 0; i < 2; i++) begin
                if (!q_req[i]) new_req(i);
            end
        end
    endtask

    // Run cycles until requester i is granted, with a bounded budget.
    task automatic wait_grant(input int i, input string tag);
        int k;
        k = 0;
        while (q_req[i] && k < 6) begin
            cycle();
            k++;
        end
        check({tag, "_granted"}, q_req[i], 0);
    endtask

    task automatic idle_reqs();
        q_req[0] = 1'b0;
        q_req[1] = 1'b0;
    endtask

    initial begin
        idle_reqs();
        for (int i = 0; i < 2; i++) begin
            q_we[i] = 1'b0; q_addr[i] = '0; q_wd[i] = '0;
        end
        drive();
        model_reset();

        // Reset: load the RAM through port A while checking idle outputs with requests pending.
        for (int i = 0; i < 32; i++) begin
            @(negedge csi_clk);
            q_req[0] = 1'b1; q_req[1] = 1'b1; q_we[0] = 1'b1; q_addr[1] = AW'(i);
            drive();
            host_we   = 1'b1;
            host_addr = AW'(i);
            host_dat  = (i == CTRL_ADDR) ? 32'h0000_00A5 : $urandom;
            mm[i]     = host_dat;
            #1;
            if (i < 2) check_reset_outputs("reset");
        end
        @(negedge csi_clk);
        idle_reqs();
        q_we[0] = 1'b0;
        drive();
        @(posedge csi_clk);
        #2 rsi_reset = 1'b0;
        model_reset();

        // Idle cycles right after release (refresh issue/mirror when enabled).
        repeat (3) cycle();

        // Write then read the same address on the next cycle.
        q_req[0] = 1'b1; q_we[0] = 1'b1; q_addr[0] = 5'd3; q_wd[0] = 32'hDEAD_BEEF;
        wait_grant(0, "t2_write");
        q_req[1] = 1'b1; q_we[1] = 1'b0; q_addr[1] = 5'd3;
        wait_grant(1, "t2_read");
        cycle();
        check("t2_r1_rvalid", r1_rvalid, 1);
        check("t2_r1_rdata", r1_rdata, 32'hDEAD_BEEF);
        check("t2_r0_rvalid", r0_rvalid, 0);

        // Continuous contention: both requesters read for 8 cycles.
        q_we[0] = 1'b0; q_addr[0] = 5'd1;
        q_we[1] = 1'b0; q_addr[1] = 5'd2;
        for (int k = 0; k < 8; k++) begin
            q_req[0] = 1'b1;
            q_req[1] = 1'b1;
            cycle();
        end
        idle_reqs();
        cycle();

        // Randomized traffic with occasional host updates of the control word.
        rand_mode = 1'b1;
        new_req(0);
        new_req(1);
        for (int k = 0; k < 1500; k++) begin
            if ((k % 300) == 150) begin
                h_we  = 1'b1;
                h_dat = $urandom;
            end
            cycle();
        end
        rand_mode = 1'b0;
        idle_reqs();
        cycle();

        // Asynchronous reset one cycle after an r1 read grant.
        q_req[1] = 1'b1; q_we[1] = 1'b0; q_addr[1] = 5'd7;
        wait_grant(1, "t5_read");
        q_req[0] = 1'b1; q_req[1] = 1'b1;
        @(posedge csi_clk);
        #2 rsi_reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        for (int k = 0; k < 3; k++) begin
            @(negedge csi_clk);
            check("reset_hold_r1_rvalid", r1_rvalid, 0);
            check("reset_hold_r0_gnt", r0_gnt, 0);
        end
        idle_reqs();
        drive();
        @(posedge csi_clk);
        #2 rsi_reset = 1'b0;
        model_reset();

        // Traffic after reset to confirm the pointer and tag restart cleanly.
        rand_mode = 1'b1;
        new_req(0);
        new_req(1);
        for (int k = 0; k < 300; k++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_portb_arbiter.md
Name: dpram_portb_arbiter

Overview:
Arbitrates port B of the 32-word x 32-bit dual-port RAM between two local requesters: r0, the effect engine, and r1, the sample streamer. Grants are round-robin, single cycle per access. The block returns read data with a fixed one-cycle latency. Optionally it periodically mirrors the control word at CTRL_ADDR into a register, so local logic sees Avalon-written settings without issuing its own reads.

Parameters:
AW, 5, RAM address width
DW, 32, RAM data width
CTRL_ADDR, 31, word address of the control word written by the host on port A
REFRESH_CYCLES, 256, csi_clk cycles between control-word refresh reads (>=2)

Ports:
csi_clk  in  1  block clock; also drives RAM port B clock
rsi_reset  in  1  asynchronous, active-high reset
r0_req  in  1  requester 0 access request; level, held until granted
r0_we  in  1  1 = write, 0 = read; stable while r0_req=1
r0_addr  in  AW  word address; stable while r0_req=1
r0_wdata  in  DW  write data; stable while r0_req=1
r0_gnt  out  1  access accepted this cycle (combinational)
r0_rvalid  out  1  read data valid for r0, one cycle
r0_rdata  out  DW  read data for r0
r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  same as r0, for requester 1
ram_address  out  AW  to RAM address_b
ram_writedata  out  DW  to RAM data_b
ram_wren  out  1  to RAM wren_b
ram_readdata  in  DW  from RAM q_b (address registered inside RAM, no output register)
ctrl_word  out  DW  mirrored control word
ctrl_valid  out  1  1 once ctrl_word holds at least one refreshed value

Behaviour:
- Reset (async, rsi_reset=1) values:
  - all gnt/rvalid = 0; ram_wren = 0; ram_address = 0; ram_writedata = 0.
  - ctrl_word = 0; ctrl_valid = 0.
  - last-served pointer = 1, so r0 wins the first tie.
  - read-pending tag cleared; refresh counter = 0.
- Transfer accepted when req=1 and gnt=1 in the same cycle. The requester drops or changes req/addr the cycle after gnt.
- Arbitration, combinational each cycle, priority order:
  - refresh_pending (feature only);
  - sole requester;
  - both requesting: grant the one not equal to the last-served pointer.
  - Pointer updates on every r0/r1 grant only.
  - At most one grant per cycle; no requester waits more than 2 cycles under continuous contention (3 with refresh).
- RAM drive: ram_address, ram_writedata and ram_wren follow the winner combinationally; ram_wren = winner.we.
  - Idle: ram_address = 0, ram_writedata = 0, ram_wren = 0.
- Read return:
  - On a granted read, register tag {valid=1, id}.
  - Next cycle, assert the selected rX_rvalid=1 and drive rX_rdata = ram_readdata.
  - The non-selected rdata holds 0.
  - Writes produce no rvalid. Write-then-read of the same address in back-to-back cycles returns the new data.
- Back-to-back: a read can be granted in the same cycle the previous read's rvalid is asserted (fully pipelined, 1 access/cycle).
- Reset mid-operation clears the pending tag; no rvalid is issued for an in-flight read.
- Writes by r0/r1 to CTRL_ADDR are allowed and are picked up by the next refresh.

Optional Feature:
- Macro: DPRAM_CTRL_MIRROR_EN.
- Defined:
  - The refresh counter decrements each cycle; when it is 0, refresh_pending=1.
  - Refresh takes the next cycle's grant: ram_address=CTRL_ADDR, ram_wren=0. r0/r1 gnt=0 that cycle, pointer unchanged.
  - The counter reloads to REFRESH_CYCLES-1 on issue.
  - One cycle later, ctrl_word <= ram_readdata and ctrl_valid <= 1 (sticky until reset).
  - The first refresh issues in the first cycle after reset release.
- Undefined: no refresh logic; ctrl_word tied 0, ctrl_valid tied 0; ports remain present.

Test Plan:
1. Reset release, macro on, RAM[31]=0x0000_00A5 -> cycle 1 ram_address=31, ram_wren=0; cycle 2 ctrl_word=0x0000_00A5, ctrl_valid=1; next refresh exactly 256 cycles after the first.
2. r0 write addr 3 data 0xDEAD_BEEF, then r1 read addr 3 next cycle -> r1_gnt=1; one cycle later r1_rvalid=1, r1_rdata=0xDEAD_BEEF, r0_rvalid=0.
3. r0_req and r1_req held high 8 cycles (reads, addr 1 and 2), macro off -> grants alternate r0,r1,r0,... starting with r0; rvalid alternates one cycle later with matching data; one grant per cycle.
4. Contention colliding with refresh (counter hits 0) -> refresh wins that cycle, r0_gnt=r1_gnt=0; the round-robin order resumes unchanged next cycle.
5. Assert rsi_reset asynchronously one cycle after r1 read grant -> r1_rvalid never asserts; all outputs at reset values immediately, not waiting for a clock edge.
6. Host writes RAM[31]=0x0000_0003 via port A mid-run, macro on -> ctrl_word updates to 0x0000_0003 within REFRESH_CYCLES+1 cycles; ctrl_valid stays 1.
